// File: rtl/if_stage.sv
// rtl/if_stage.sv - byte-serial instruction fetch stage assembling 32-bit words for decode
// Optional one-entry skid buffer enabled by defining IF_SKID_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_a,
  output logic        mem_rd,
  input  logic [7:0]  mem_din,
  input  logic        jmp_en,
  input  logic [31:0] jmp_pc,
  input  logic        rdy_in,
  output logic        vld_out,
  output logic [31:0] pc_out,
  output logic [31:0] is_out
);

  typedef enum logic [2:0] {
    S_B0   = 3'd0,
    S_B1   = 3'd1,
    S_B2   = 3'd2,
    S_B3   = 3'd3,
    S_LAST = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [23:0] word_q, word_d;
  logic        vld_q, vld_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] is_q, is_d;
  logic        xfer;
  logic [31:0] new_word;

`ifdef IF_SKID_EN
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_is_q, skid_is_d;
`endif

  logic unused_jmp_lsb;
  assign unused_jmp_lsb = ^jmp_pc[1:0];

  assign xfer     = vld_q & rdy_in;
  assign new_word = {mem_din, word_q};
  assign vld_out  = vld_q;
  assign pc_out   = pc_q;
  assign is_out   = is_q;

  // Memory request: rd is gated by rst_n so it drops the instant reset asserts.
  always_comb begin
    mem_rd = 1'b0;
    mem_a  = fpc_q;
    case (state_q)
      S_B0: begin mem_rd = rst_n; mem_a = fpc_q;          end
      S_B1: begin mem_rd = rst_n; mem_a = fpc_q + 32'd1;  end
      S_B2: begin mem_rd = rst_n; mem_a = fpc_q + 32'd2;  end
      S_B3: begin mem_rd = rst_n; mem_a = fpc_q + 32'd3;  end
      default: begin mem_rd = 1'b0; mem_a = fpc_q;        end
    endcase
  end

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    word_d  = word_q;
    vld_d   = vld_q;
    pc_d    = pc_q;
    is_d    = is_q;
`ifdef IF_SKID_EN
    skid_vld_d = skid_vld_q;
    skid_pc_d  = skid_pc_q;
    skid_is_d  = skid_is_q;
`endif

    // Output register drains first; a waiting skid entry refills it.
    if (xfer) begin
      vld_d = 1'b0;
`ifdef IF_SKID_EN
      if (skid_vld_q) begin
        vld_d      = 1'b1;
        pc_d       = skid_pc_q;
        is_d       = skid_is_q;
        skid_vld_d = 1'b0;
      end
`endif
    end

    case (state_q)
      S_B0: state_d = S_B1;
      S_B1: begin word_d[7:0]   = mem_din; state_d = S_B2;   end
      S_B2: begin word_d[15:8]  = mem_din; state_d = S_B3;   end
      S_B3: begin word_d[23:16] = mem_din; state_d = S_LAST; end
      S_LAST: begin
        fpc_d = fpc_q + 32'd4;
`ifdef IF_SKID_EN
        if (!vld_q || (rdy_in && !skid_vld_q)) begin
          vld_d   = 1'b1;
          pc_d    = fpc_q;
          is_d    = new_word;
          state_d = S_B0;
        end else begin
          skid_vld_d = 1'b1;
          skid_pc_d  = fpc_q;
          skid_is_d  = new_word;
          state_d    = S_HOLD;
        end
`else
        // Fetch only restarts after a transfer, so the output is always free here.
        vld_d   = 1'b1;
        pc_d    = fpc_q;
        is_d    = new_word;
        state_d = S_HOLD;
`endif
      end
      S_HOLD: begin
        if (xfer) state_d = S_B0;
      end
      default: state_d = S_B0;
    endcase

    // A redirect overrides everything except the transfer already counted above.
    if (jmp_en) begin
      state_d = S_B0;
      fpc_d   = {jmp_pc[31:2], 2'b00};
      vld_d   = 1'b0;
      word_d  = 24'h0;
`ifdef IF_SKID_EN
      skid_vld_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_B0;
      fpc_q   <= RESET_PC;
      word_q  <= 24'h0;
      vld_q   <= 1'b0;
      pc_q    <= 32'h0;
      is_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      pc_q    <= pc_d;
      is_q    <= is_d;
    end
  end

`ifdef IF_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_vld_q <= 1'b0;
      skid_pc_q  <= 32'h0;
      skid_is_q  <= 32'h0;
    end else begin
      skid_vld_q <= skid_vld_d;
      skid_pc_q  <= skid_pc_d;
      skid_is_q  <= skid_is_d;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage against an instruction-stream model
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_a, mem_a2;
  logic        mem_rd, mem_rd2;
  logic [7:0]  mem_din, mem_din2;
  logic        jmp_en;
  logic [31:0] jmp_pc;
  logic        rdy_in;
  logic        vld_out, vld2;
  logic [31:0] pc_out, pc2;
  logic [31:0] is_out, is2;

  int          n_checks, n_errors;
  int          cyc, last_xfer, gap, n2, cnt;
  logic [31:0] exp_pc;
  logic [31:0] first_a;
  bit          seen;

`ifdef IF_SKID_EN
  localparam int PERIOD = 5;
  localparam int HOLD_FETCHES = 4;
`else
  localparam int PERIOD = 6;
  localparam int HOLD_FETCHES = 0;
`endif

  if_stage #(.RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_a(mem_a), .mem_rd(mem_rd), .mem_din(mem_din),
    .jmp_en(jmp_en), .jmp_pc(jmp_pc), .rdy_in(rdy_in),
    .vld_out(vld_out), .pc_out(pc_out), .is_out(is_out)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .mem_a(mem_a2), .mem_rd(mem_rd2), .mem_din(mem_din2),
    .jmp_en(1'b0), .jmp_pc(32'h0), .rdy_in(1'b1),
    .vld_out(vld2), .pc_out(pc2), .is_out(is2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'd0) return 8'h13;
    if (a == 32'd1) return 8'h05;
    if (a == 32'd2) return 8'h10;
    if (a == 32'd3) return 8'h00;
    h = a * 32'h9E37_79B1;
    return h[23:16];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  always @(posedge clk) begin
    if (mem_rd)  mem_din  <= mb(mem_a);
    if (mem_rd2) mem_din2 <= mb(mem_a2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; the model consumes the transfer and redirect seen at this edge.
  task automatic tick();
    bit          xf, hold, jt;
    logic [31:0] p, i;
    xf   = rst_n && vld_out && rdy_in;
    hold = rst_n && vld_out && !rdy_in && !jmp_en;
    jt   = rst_n && jmp_en;
    p    = pc_out;
    i    = is_out;
    if (xf) begin
      check("xfer_pc", pc_out, exp_pc);
      check("xfer_is", is_out, word_at(exp_pc));
      exp_pc   += 32'd4;
      gap       = cyc - last_xfer;
      last_xfer = cyc;
    end
    if (jt) exp_pc = {jmp_pc[31:2], 2'b00};
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (hold) begin
      check("stall_vld", {31'b0, vld_out}, 32'd1);
      check("stall_pc", pc_out, p);
      check("stall_is", is_out, i);
    end
    if (jt) check("jmp_vld_clr", {31'b0, vld_out}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && vld2 && n2 < 2) begin
      check(n2 == 0 ? "wrap_pc0" : "wrap_pc1", pc2, n2 == 0 ? 32'hFFFF_FFFC : 32'h0);
      check("wrap_is", is2, word_at(pc2));
      n2++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; last_xfer = 0; gap = 0; n2 = 0;
    rst_n = 1'b0; rdy_in = 1'b1; jmp_en = 1'b0; jmp_pc = 32'h0;
    mem_din = 8'h0; mem_din2 = 8'h0; exp_pc = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_vld", {31'b0, vld_out}, 32'd0);
    check("rst_rd", {31'b0, mem_rd}, 32'd0);
    check("rst_a", mem_a, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_is", is_out, 32'h0);
    check("rst_a_wrap", mem_a2, 32'hFFFF_FFFC);

    // Basic fetch timing from reset release
    rst_n = 1'b1;
    #1;
    check("c0_rd", {31'b0, mem_rd}, 32'd1);
    check("c0_a", mem_a, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 3) check("ck_a", mem_a, k);
      if (k == 4) check("c4_rd", {31'b0, mem_rd}, 32'd0);
    end
    check("c5_vld", {31'b0, vld_out}, 32'd1);
    check("c5_pc", pc_out, 32'h0);
    check("c5_is", is_out, 32'h0010_0513);
    tick();
    check("c6_vld", {31'b0, vld_out}, 32'd0);

    // Decode stalls for 10 cycles after the next word appears
    rdy_in = 1'b0;
    for (int k = 0; k < 40 && !vld_out; k++) tick();
    check("stall_wait", {31'b0, vld_out}, 32'd1);
    cnt = 0; seen = 0; first_a = 32'h0;
    for (int k = 0; k < 10; k++) begin
      if (mem_rd) begin
        if (!seen) first_a = mem_a;
        seen = 1;
        cnt++;
      end
      tick();
    end
    check("stall_fetches", cnt, HOLD_FETCHES);
    if (seen) check("stall_fetch_a", first_a, pc_out + 32'd4);
    rdy_in = 1'b1;
    repeat (15) tick();

    // Redirect during S_B2
    for (int k = 0; k < 20 && !(mem_rd && mem_a[1:0] == 2'd2); k++) tick();
    check("b2_found", {30'b0, mem_a[1:0]}, 32'd2);
    jmp_en = 1'b1; jmp_pc = 32'h0000_1007;
    tick();
    jmp_en = 1'b0;
    check("jmp_a", mem_a, 32'h0000_1004);
    check("jmp_rd", {31'b0, mem_rd}, 32'd1);
    for (int k = 0; k < 20 && !vld_out; k++) tick();
    check("jmp_pc_out", pc_out, 32'h0000_1004);

    // Redirect coincident with a transfer
    for (int k = 0; k < 20 && !vld_out; k++) tick();
    jmp_en = 1'b1; jmp_pc = 32'h0000_2002;
    tick();
    jmp_en = 1'b0;
    check("jx_a", mem_a, 32'h0000_2000);
    repeat (20) tick();

    // Asynchronous reset in S_B3
    for (int k = 0; k < 20 && !(mem_rd && mem_a[1:0] == 2'd3); k++) tick();
    rst_n = 1'b0;
    #1;
    check("arst_vld", {31'b0, vld_out}, 32'd0);
    check("arst_rd", {31'b0, mem_rd}, 32'd0);
    exp_pc = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_refetch_a", mem_a, 32'h0);
    check("arst_refetch_rd", {31'b0, mem_rd}, 32'd1);
    for (int k = 0; k < 20 && !vld_out; k++) tick();
    check("arst_pc", pc_out, 32'h0);

    // Randomized backpressure and redirects
    for (int k = 0; k < 3000; k++) begin
      rdy_in = ($urandom_range(0, 9) < 7);
      jmp_en = ($urandom_range(0, 99) < 3);
      jmp_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      tick();
    end
    jmp_en = 1'b0;

    // Steady-state throughput
    rdy_in = 1'b1;
    repeat (40) tick();
    check("throughput", gap, PERIOD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0, fetch address after reset (bits [1:0] SHALL be 0).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 mem_a  out  32  byte address to instruction memory.
REQ-005 mem_rd  out  1  read strobe; byte for mem_a returned on mem_din in the next cycle.
REQ-006 mem_din  in  8  read data byte.
REQ-007 jmp_en  in  1  one-cycle redirect request from execute.
REQ-008 jmp_pc  in  32  redirect target; bits [1:0] ignored.
REQ-009 rdy_in  in  1  decode ready; transfer when vld_out & rdy_in.
REQ-010 vld_out  out  1  pc_out/is_out hold a valid instruction.
REQ-011 pc_out  out  32  address of presented instruction.
REQ-012 is_out  out  32  presented instruction word, little-endian assembled.

Function
REQ-013 Fetch FSM states S_B0, S_B1, S_B2, S_B3, S_LAST, S_HOLD; S_Bk drives mem_rd=1, mem_a=fpc+k.
REQ-014 Sequence S_B0->S_B1->S_B2->S_B3->S_LAST, one cycle each; byte k captured into word bits [8k+7:8k] in the cycle after S_Bk.
REQ-015 S_LAST: mem_rd=0; byte 3 captured; assembled word and fpc written to output register if free (vld_out=0 or rdy_in=1), else to skid entry (REQ-026); fpc <= fpc+4.
REQ-016 Output visible (vld_out=1) the cycle after S_LAST; earliest is 5 cycles after S_B0.
REQ-017 pc_out, is_out, vld_out SHALL be stable while vld_out=1 and rdy_in=0.
REQ-018 vld_out & rdy_in with no replacement loaded clears vld_out next cycle.
REQ-019 S_HOLD: mem_rd=0; leave to S_B0 the cycle after the blocking entry drains.
REQ-020 jmp_en=1 has priority over every other event: next cycle FSM=S_B0, fpc={jmp_pc[31:2],2'b00}, vld_out=0, skid cleared, captured partial word and pending byte discarded.
REQ-021 jmp_en coincident with vld_out & rdy_in: the transfer counts; flush still applies to all other state.
REQ-022 fpc wraps 32'hFFFFFFFC -> 32'h0 with no error.
REQ-023 mem_a=fpc and mem_rd=0 outside S_B0..S_B3.

Reset
REQ-024 rst_n low: FSM=S_B0, fpc=RESET_PC, vld_out=0, pc_out=0, is_out=0, skid empty, mem_rd=0, mem_a=RESET_PC; applied asynchronously, including mid-fetch.
REQ-025 First S_B0 (mem_rd=1) in the first clock cycle after rst_n deasserts.

Configuration
REQ-026 Macro IF_SKID_EN defined: one-entry skid buffer; after S_LAST go to S_B0 directly; word finishing while output occupied goes to skid; skid moves to output on transfer; S_HOLD entered only when skid full and output occupied; rdy_in held 1 gives one instruction per 5 cycles.
REQ-027 IF_SKID_EN undefined: no skid storage; after S_LAST go to S_HOLD until vld_out & rdy_in, then S_B0; rdy_in held 1 gives one instruction per 6 cycles.

Verification
REQ-028 Reset release, RESET_PC=0, mem bytes 13 05 10 00 at 0..3, rdy_in=1 -> mem_a 0,1,2,3 cycles 0..3; cycle 5 vld_out=1, pc_out=0, is_out=32'h00100513.
REQ-029 rdy_in=0 for 10 cycles after first vld_out -> pc_out/is_out unchanged, no new word at output; skid off: mem_rd=0 throughout; skid on: exactly one further fetch (pc 4) then mem_rd=0.
REQ-030 jmp_en=1, jmp_pc=32'h00001007 during S_B2 -> next cycle mem_a=32'h00001004, vld_out=0; next instruction pc_out=32'h00001004.
REQ-031 rst_n pulsed low during S_B3 -> immediately vld_out=0, mem_rd=0; refetch from RESET_PC after release.
REQ-032 RESET_PC=32'hFFFFFFFC, rdy_in=1 -> pc_out FFFFFFFC then 00000000.
REQ-033 jmp_en in same cycle as vld_out & rdy_in -> instruction taken by decode exactly once, vld_out=0 next cycle, fetch restarts at jmp_pc.
